draw_grid_status: RTL

Parametrised grid renderer for the VGA pipeline: it maps each incoming pixel to a cell of a ROWS×COLUMNS board and fetches that cell's status from an external synchronous memory. The pixel is painted according to the status (empty, ship, hit, miss), and a blinking cursor outline is drawn over one selected cell. It sits in the VGA chain after the grid-line drawer, once per board (player and enemy), and forwards all timing signals with a fixed latency.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/delay.sv | 27 ++
 rtl/draw_grid_status.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-pipeline types: board cell status, paint colours and pixel classes.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SHIP  = 2'd1,
    ST_HIT   = 2'd2,
    ST_MISS  = 2'd3
  } status_t;

  localparam logic [11:0] SHIP_RGB   = 12'h888;
  localparam logic [11:0] HIT_RGB    = 12'hF00;
  localparam logic [11:0] MISS_RGB   = 12'h00F;
  localparam logic [11:0] CURSOR_RGB = 12'hFF0;

  typedef enum logic [2:0] {
    PIX_BLANK  = 3'd0,
    PIX_OUT    = 3'd1,
    PIX_BORDER = 3'd2,
    PIX_CURSOR = 3'd3,
    PIX_FILL   = 3'd4
  } pix_class_t;

  // Empty cells let the background from earlier pipeline stages show through.
  function automatic logic [11:0] status_rgb(input logic [1:0] status,
                                             input logic [11:0] base_rgb);
    case (status)
      ST_SHIP: return SHIP_RGB;
      ST_HIT:  return HIT_RGB;
      ST_MISS: return MISS_RGB;
      default: return base_rgb;
    endcase
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
`default_nettype none
module delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule
`default_nettype wire

// File: rtl/draw_grid_status.sv
// Paints board cells by their memory status and overlays a blinking cursor ring,
// forwarding VGA timing with a constant MEM_LAT+2 cycle latency.
`default_nettype none
module draw_grid_status
  import vga_pkg::*;
#(
  parameter int X_POS        = 0,
  parameter int Y_POS        = 0,
  parameter int GRID_ROWS    = 12,
  parameter int GRID_COLUMNS = 12,
  parameter int CELL_LOG2    = 5,
  parameter int BORDER_WIDTH = 2,
  parameter int ADDR_W       = 8,
  parameter int MEM_LAT      = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       in_hcount,
  input  logic [10:0]       in_vcount,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_hblnk,
  input  logic              in_vblnk,
  input  logic [11:0]       in_rgb,
  input  logic [1:0]        grid_status,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_row,
  input  logic [ADDR_W-1:0] cursor_col,
  output logic [ADDR_W-1:0] grid_addr,
  output logic [10:0]       out_hcount,
  output logic [10:0]       out_vcount,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_hblnk,
  output logic              out_vblnk,
  output logic [11:0]       out_rgb
);

  localparam int CELL   = 1 << CELL_LOG2;
  localparam int GRID_W = GRID_COLUMNS << CELL_LOG2;
  localparam int GRID_H = GRID_ROWS << CELL_LOG2;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_t;

  logic [10:0]          rx, ry, col, row;
  logic [CELL_LOG2-1:0] lx, ly;
  logic                 in_grid, is_border, is_ring, on_cursor;
  logic [ADDR_W-1:0]    addr_next;
  pix_class_t           cls_next, cls_s1, cls_out;
  logic [2:0]           cls_dly;
  logic                 vs_prev, vs_rise;
  logic [ADDR_W-1:0]    cur_row, cur_col;
  blink_t               blink;
  logic [FC_W-1:0]      frame_cnt;
  logic [37:0]          vga_dly;
  logic [11:0]          rgb_next;

  // Subtraction wraps, so pixels left of / above the grid land far outside it.
  assign rx      = in_hcount - 11'(X_POS);
  assign ry      = in_vcount - 11'(Y_POS);
  assign in_grid = (32'(rx) < GRID_W) && (32'(ry) < GRID_H);
  assign col     = rx >> CELL_LOG2;
  assign row     = ry >> CELL_LOG2;
  assign lx      = rx[CELL_LOG2-1:0];
  assign ly      = ry[CELL_LOG2-1:0];

  assign addr_next = ADDR_W'(32'(row) * 32'(GRID_COLUMNS) + 32'(col));
  assign is_border = (32'(lx) < BORDER_WIDTH) || (32'(ly) < BORDER_WIDTH);
  assign is_ring   = (32'(lx) < 2 * BORDER_WIDTH) || (32'(ly) < 2 * BORDER_WIDTH) ||
                     (32'(lx) >= CELL - BORDER_WIDTH) || (32'(ly) >= CELL - BORDER_WIDTH);
  assign on_cursor = (32'(row) == 32'(cur_row)) && (32'(col) == 32'(cur_col));
  assign vs_rise   = in_vsync && !vs_prev;

  always_comb begin
    if (in_hblnk || in_vblnk)                                   cls_next = PIX_BLANK;
    else if (!in_grid)                                          cls_next = PIX_OUT;
    else if (is_border)                                         cls_next = PIX_BORDER;
    else if (is_ring && on_cursor && cursor_en && blink == BLINK_ON) cls_next = PIX_CURSOR;
    else                                                        cls_next = PIX_FILL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid_addr <= '0;
      cls_s1    <= PIX_BLANK;
    end else begin
      if (in_grid) grid_addr <= addr_next;
      cls_s1 <= cls_next;
    end
  end

  // Cursor is only re-read at frame start so it never moves mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev <= 1'b0;
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      vs_prev <= in_vsync;
      if (vs_rise) begin
        cur_row <= cursor_row;
        cur_col <= cursor_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink     <= BLINK_ON;
      frame_cnt <= '0;
    end else if (!cursor_en) begin
      blink     <= BLINK_ON;
      frame_cnt <= '0;
    end else if (vs_rise) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink     <= (blink == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  delay #(.WIDTH(38), .CLK_DEL(MEM_LAT + 1)) u_vga_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb}),
    .dout (vga_dly)
  );

  delay #(.WIDTH(3), .CLK_DEL(MEM_LAT)) u_class_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (cls_s1),
    .dout (cls_dly)
  );

  assign cls_out = pix_class_t'(cls_dly);

  always_comb begin
    rgb_next = vga_dly[11:0];
    case (cls_out)
      PIX_BLANK:  rgb_next = 12'h000;
      PIX_CURSOR: rgb_next = CURSOR_RGB;
      PIX_FILL:   rgb_next = status_rgb(grid_status, vga_dly[11:0]);
      default:    rgb_next = vga_dly[11:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= '0;
      out_rgb <= '0;
    end else begin
      {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= vga_dly[37:12];
      out_rgb <= rgb_next;
    end
  end

endmodule
`default_nettype wire
